// File: rtl/mfu_accumulator.sv
// Precision-scalable accumulator behind the multi-precision multiplier: sums packed
// product words into 1, 2 or 4 signed lanes and presents the result on a valid/ready port.
module mfu_accumulator #(
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           cfg_mode,
    input  logic [LEN_W-1:0]     cfg_len,
    output logic [1:0]           job_mode,
    output logic                 busy,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [15:0]          in_p,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*ACC_W-1:0]   out_data,
    output logic [3:0]           out_ovf,
    output logic [1:0]           out_mode
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_8X8 = 2'b01;
    localparam logic [1:0] MODE_4X4 = 2'b10;
    localparam logic [1:0] MODE_2X2 = 2'b11;

    state_t                    state_q, state_d;
    logic [1:0]                mode_q, mode_d;
    logic [LEN_W-1:0]          len_q, len_d;
    logic [LEN_W-1:0]          cnt_q, cnt_d;
    logic [3:0][ACC_W-1:0]     acc_q, acc_d;
    logic [3:0]                ovf_q, ovf_d;

    logic [3:0][ACC_W-1:0]     addend;
    logic [3:0][ACC_W-1:0]     sum;
    logic [3:0]                ovf_set;
    logic                      job_start;
    logic                      beat;
    logic                      last_beat;

    assign job_start = (state_q == S_IDLE) && start;
    assign beat      = (state_q == S_ACC) && in_valid;
    assign last_beat = (cnt_q + LEN_W'(1)) == len_q;

    // Lane fields are signed; NOOP and lanes unused by the mode contribute zero.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        addend = '0;
        case (mode_q)
            MODE_8X8: addend[0] = ACC_W'($signed(in_p));
            MODE_4X4: begin
                addend[1] = ACC_W'($signed(in_p[15:8]));
                addend[0] = ACC_W'($signed(in_p[7:0]));
            end
            MODE_2X2: begin
                for (int n = 0; n < 4; n++) begin
                    addend[n] = ACC_W'($signed(in_p[4*n +: 4]));
                end
            end
            default: ;
        endcase
    end

    // Signed overflow: operands share a sign and the wrapped sum does not.
    always_comb begin
        sum     = '0;
        ovf_set = '0;
        for (int n = 0; n < 4; n++) begin
            sum[n]     = acc_q[n] + addend[n];
            ovf_set[n] = (addend[n][ACC_W-1] == acc_q[n][ACC_W-1]) &&
                         (sum[n][ACC_W-1] != acc_q[n][ACC_W-1]);
        end
    end

    always_comb begin
        mode_d = mode_q;
        len_d  = len_q;
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        ovf_d  = ovf_q;
        if (job_start) begin
            mode_d = cfg_mode;
            len_d  = cfg_len;
            cnt_d  = '0;
            acc_d  = '0;
            ovf_d  = '0;
        end else if (beat) begin
            cnt_d = cnt_q + LEN_W'(1);
            acc_d = sum;
            ovf_d = ovf_q | ovf_set;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            mode_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
            acc_q  <= '0;
            ovf_q  <= '0;
        end else begin
            mode_q <= mode_d;
            len_q  <= len_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            ovf_q  <= ovf_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = (cfg_len == '0) ? S_OUT : S_ACC;
            S_ACC:  if (beat && last_beat) state_d = S_OUT;
            S_OUT:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        in_ready  = (state_q == S_ACC);
        out_valid = (state_q == S_OUT);
    end

    assign job_mode = mode_q;
    assign out_mode = mode_q;
    assign out_data = acc_q;
    assign out_ovf  = ovf_q;

endmodule

// File: tb/tb_mfu_accumulator.sv
// Directed bench for mfu_accumulator: a 24-bit and a 16-bit instance share stimulus,
// so the narrow one exercises lane overflow.
module tb_mfu_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_len;
    logic        in_valid;
    logic [15:0] in_p;
    logic        out_ready;

    logic [1:0]  job_mode, job_mode16;
    logic        busy, busy16;
    logic        in_ready, in_ready16;
    logic        out_valid, out_valid16;
    logic [95:0] out_data;
    logic [63:0] out_data16;
    logic [3:0]  out_ovf, out_ovf16;
    logic [1:0]  out_mode, out_mode16;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mfu_accumulator #(.ACC_W(24), .LEN_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_mode(cfg_mode), .cfg_len(cfg_len),
        .job_mode(job_mode), .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
        .in_p(in_p), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ovf(out_ovf), .out_mode(out_mode)
    );

    mfu_accumulator #(.ACC_W(16), .LEN_W(8)) dut16 (
        .clk(clk), .rst(rst), .start(start), .cfg_mode(cfg_mode), .cfg_len(cfg_len),
        .job_mode(job_mode16), .busy(busy16), .in_valid(in_valid), .in_ready(in_ready16),
        .in_p(in_p), .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16),
        .out_ovf(out_ovf16), .out_mode(out_mode16)
    );

    typedef struct packed {
        logic [1:0]        mode;
        logic [7:0]        len;
        logic [0:3][15:0]  p;
        int                bubble_at;
        logic [95:0]       exp_data;
        logic [3:0]        exp_ovf;
        logic [63:0]       exp16_data;
        logic [3:0]        exp16_ovf;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called on a negedge; returns on the negedge after the last beat was accepted.
    task automatic run_job(input logic [1:0] mode, input logic [7:0] len,
                           input logic [0:3][15:0] p, input int bubble_at);
        start    = 1'b1;
        cfg_mode = mode;
        cfg_len  = len;
        @(negedge clk);
        start = 1'b0;
        check("job_mode", 96'(job_mode), 96'(mode));
        check("busy_after_start", 96'(busy), 96'(1));
        for (int i = 0; i < int'(len); i++) begin
            if (i == bubble_at) begin
                repeat (2) @(negedge clk);
            end
            check("in_ready_acc", 96'(in_ready), 96'(1));
            in_valid = 1'b1;
            in_p     = p[i % 4];
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_after_hs", 96'(out_valid), 96'(0));
        check("busy_after_hs", 96'(busy), 96'(0));
    endtask

    initial begin
        vecs[0] = '{mode: 2'b01, len: 8'd3, p: {16'h0100, 16'hFF00, 16'h0005, 16'h0000},
                    bubble_at: -1,
                    exp_data: {24'h0, 24'h0, 24'h0, 24'h000005}, exp_ovf: 4'h0,
                    exp16_data: {16'h0, 16'h0, 16'h0, 16'h0005}, exp16_ovf: 4'h0};
        vecs[1] = '{mode: 2'b10, len: 8'd2, p: {16'h7F80, 16'h7F80, 16'h0, 16'h0},
                    bubble_at: -1,
                    exp_data: {24'h0, 24'h0, 24'h0000FE, 24'hFFFF00}, exp_ovf: 4'h0,
                    exp16_data: {16'h0, 16'h0, 16'h00FE, 16'hFF00}, exp16_ovf: 4'h0};
        vecs[2] = '{mode: 2'b11, len: 8'd4, p: {16'h1F78, 16'h1F78, 16'h1F78, 16'h1F78},
                    bubble_at: 2,
                    exp_data: {24'h000004, 24'hFFFFFC, 24'h00001C, 24'hFFFFE0}, exp_ovf: 4'h0,
                    exp16_data: {16'h0004, 16'hFFFC, 16'h001C, 16'hFFE0}, exp16_ovf: 4'h0};
        vecs[3] = '{mode: 2'b01, len: 8'd2, p: {16'h7FFF, 16'h7FFF, 16'h0, 16'h0},
                    bubble_at: -1,
                    exp_data: {24'h0, 24'h0, 24'h0, 24'h00FFFE}, exp_ovf: 4'h0,
                    exp16_data: {16'h0, 16'h0, 16'h0, 16'hFFFE}, exp16_ovf: 4'h1};
        // NOOP right after the overflowing job: beats count, sums and flags return to zero.
        vecs[4] = '{mode: 2'b00, len: 8'd2, p: {16'h1234, 16'h8765, 16'h0, 16'h0},
                    bubble_at: -1,
                    exp_data: 96'h0, exp_ovf: 4'h0,
                    exp16_data: 64'h0, exp16_ovf: 4'h0};

        rst = 1'b1; start = 1'b0; cfg_mode = 2'b00; cfg_len = 8'd0;
        in_valid = 1'b0; in_p = 16'h0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 96'(busy), 96'(0));
        check("rst_in_ready", 96'(in_ready), 96'(0));
        check("rst_out_valid", 96'(out_valid), 96'(0));
        check("rst_out_data", out_data, 96'h0);
        check("rst_out_ovf", 96'(out_ovf), 96'(0));
        check("rst_modes", 96'({job_mode, out_mode}), 96'(0));
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            run_job(vecs[v].mode, vecs[v].len, vecs[v].p, vecs[v].bubble_at);
            check($sformatf("v%0d_out_valid", v), 96'(out_valid), 96'(1));
            check($sformatf("v%0d_in_ready", v), 96'(in_ready), 96'(0));
            check($sformatf("v%0d_out_data", v), out_data, vecs[v].exp_data);
            check($sformatf("v%0d_out_ovf", v), 96'(out_ovf), 96'(vecs[v].exp_ovf));
            check($sformatf("v%0d_out_mode", v), 96'(out_mode), 96'(vecs[v].mode));
            check($sformatf("v%0d_data16", v), 96'(out_data16), 96'(vecs[v].exp16_data));
            check($sformatf("v%0d_ovf16", v), 96'(out_ovf16), 96'(vecs[v].exp16_ovf));
            handshake();
        end

        // Backpressure: result held, start and in_valid ignored while OUT waits.
        run_job(2'b01, 8'd1, {16'h0003, 16'h0, 16'h0, 16'h0}, -1);
        start = 1'b1; cfg_mode = 2'b10; cfg_len = 8'd5;
        in_valid = 1'b1; in_p = 16'h0100;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            check("bp_out_valid", 96'(out_valid), 96'(1));
            check("bp_in_ready", 96'(in_ready), 96'(0));
            check("bp_out_data", out_data, 96'h3);
            check("bp_out_mode", 96'(out_mode), 96'(2'b01));
        end
        in_valid = 1'b0;
        handshake();

        // Zero-length job started on the first idle cycle after the handshake.
        run_job(2'b10, 8'd0, {16'h0, 16'h0, 16'h0, 16'h0}, -1);
        check("len0_out_valid", 96'(out_valid), 96'(1));
        check("len0_in_ready", 96'(in_ready), 96'(0));
        check("len0_out_data", out_data, 96'h0);
        check("len0_out_mode", 96'(out_mode), 96'(2'b10));
        handshake();

        // Reset in the middle of a five-term job.
        start = 1'b1; cfg_mode = 2'b01; cfg_len = 8'd5;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1; in_p = 16'h0100;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        check("mid_partial", out_data, 96'h200);
        check("mid_busy", 96'(busy), 96'(1));
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", 96'(busy), 96'(0));
        check("mid_rst_in_ready", 96'(in_ready), 96'(0));
        check("mid_rst_out_valid", 96'(out_valid), 96'(0));
        check("mid_rst_out_data", out_data, 96'h0);
        check("mid_rst_modes", 96'({job_mode, out_mode, out_ovf}), 96'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_idle", 96'({busy, out_valid}), 96'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mfu_accumulator.md
# mfu_accumulator

Precision-scalable accumulation stage directly downstream of the multi-precision multiplier functional unit. It consumes the unit's registered 16-bit packed product word and sums it into 1, 2 or 4 signed lane accumulators, depending on precision mode (8x8, 4x4, 2x2). After a programmed number of terms it presents the packed lane sums, with per-lane overflow flags, on a valid/ready output port. Jobs are started by a controller pulse, and the latched job mode also drives the multiplier's mode input.

## Interface
- ACC_W, 24: width of each lane accumulator (min 16).
- LEN_W, 8: width of the job term count.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  job start pulse; sampled only in IDLE.
- cfg_mode  in  2  job mode: 00 NOOP, 01 8x8, 10 4x4, 11 2x2; latched on start.
- cfg_len  in  LEN_W  number of product terms in the job; latched on start.
- job_mode  out  2  latched mode; drives the multiplier mode input.
- busy  out  1  high whenever state is not IDLE.
- in_valid  in  1  product word valid; upstream aligns it to the multiplier's 1-cycle output register.
- in_ready  out  1  high only in ACC.
- in_p  in  16  packed product word.
- out_valid  out  1  result valid; high only in OUT.
- out_ready  in  1  downstream accepts the result.
- out_data  out  4*ACC_W  lane sums; lane n occupies [n*ACC_W +: ACC_W].
- out_ovf  out  4  sticky signed-overflow flag per lane.
- out_mode  out  2  mode of the presented result.

## Operation
- States: IDLE, ACC, OUT.
- IDLE → ACC on start when cfg_len != 0. On that transition:
  - latch mode and len into the job registers;
  - clear all four accumulators, out_ovf and the term counter.
- IDLE → OUT on start when cfg_len == 0. Accumulators are cleared and no input is consumed.
- start is ignored in ACC and OUT.
- ACC: each beat with in_valid & in_ready adds the sign-extended lane fields to the accumulators and increments the counter. The beat that makes counter == len moves the FSM to OUT.
- OUT: out_valid held high. On out_valid & out_ready → IDLE.
- Lane extraction from in_p (each field is signed two's complement, sign-extended to ACC_W):
  - 8x8: lane0 = in_p[15:0].
  - 4x4: lane1 = in_p[15:8], lane0 = in_p[7:0].
  - 2x2: lane3 = [15:12], lane2 = [11:8], lane1 = [7:4], lane0 = [3:0].
  - NOOP: beats are consumed and counted, but all lanes add zero.
- Lanes unused by the mode stay zero, and their ovf bits stay zero.
- Accumulation wraps modulo 2^ACC_W.
- out_ovf[n] is set when the addend and the old accumulator value have equal sign and the new sum's sign differs. It stays set until the next start.
- out_data, out_ovf and out_mode reflect the accumulator registers directly. They are held stable throughout OUT.

## Timing
- Reset values: state IDLE; in_ready 0, out_valid 0, busy 0, out_data 0, out_ovf 0, out_mode 0, job_mode 0.
- Start accepted at edge t: busy and in_ready are high from t+1 (ACC), and job_mode is valid from t+1.
- Throughput: one term per cycle. in_valid low inserts bubbles with no state change.
- Last term accepted at edge k: out_valid = 1 from k+1 with the final sums. in_ready = 0 from k+1.
- len == 0: out_valid = 1 at t+1, out_data = 0.
- Output handshake at edge m: out_valid = 0 and busy = 0 from m+1. The earliest new start is accepted at m+1.
- in_valid in IDLE or OUT is not consumed and has no effect.
- Reset asserted mid-job (any state): immediate return to reset values. Partial sums are discarded, and no output is produced for that job.

## Test plan
- 8x8, len=3, in_p = 0x0100, 0xFF00, 0x0005 → out_data lane0 = 0x000005, lanes1-3 = 0, out_ovf = 0, out_mode = 01.
- 4x4, len=2, in_p = 0x7F80 twice → lane1 = 0x0000FE, lane0 = 0xFFFF00 (-256), lanes 2-3 = 0.
- 2x2, len=4, in_p = 0x1F78 ×4, with in_valid low for 2 cycles between beats 2 and 3 → lanes 3..0 = 4, -4, 28, -32 (0xFFFFE0). Bubbles must not count as terms.
- Backpressure: hold out_ready low 3 cycles in OUT → out_data stable, in_ready 0, a start pulse is ignored. Raise out_ready → busy 0 next cycle, then a new start is accepted.
- ACC_W=16, 8x8, len=2, in_p = 0x7FFF twice → lane0 = 0xFFFE, out_ovf = 0001. Next job → ovf cleared.
- len=0 → out_valid one cycle after start with zeros. A second job: assert rst after 2 of 5 beats → all outputs at reset values immediately, busy 0.
